// File: rtl/ls_unit.sv
// ls_unit: load/store unit with IDLE/ACCESS/DONE handshake to data memory.
// Ports: req_* decoded request, stall/done/rdata/err to core, dmem_* memory side, dhit completion.
module ls_unit #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            req_valid,
  input  logic            req_wen,
  input  logic [1:0]      req_width,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] rdata,
  output logic            err,
  output logic            dmem_ren,
  output logic            dmem_wen,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_store,
  output logic [1:0]      dmem_width,
  input  logic [XLEN-1:0] dmem_load,
  input  logic            dhit
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t          state;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [1:0]      width_q;
  logic            wen_q;
  logic            uns_q;
  logic [CW-1:0]   cnt;

  logic            legal;
  logic            tmo;
  logic [6:0]      sh;
  logic [XLEN-1:0] lsh;
  logic signed [XLEN-1:0] slsh;
  logic [XLEN-1:0] zx;
  logic [XLEN-1:0] sx;
  logic [XLEN-1:0] ext;

  always_comb begin
    legal = 1'b0;
    unique case (req_width)
      2'b00: legal = 1'b1;
      2'b01: legal = ~req_addr[0];
      2'b10: legal = (req_addr[1:0] == 2'b00);
      2'b11: legal = (XLEN == 64) && (req_addr[2:0] == 3'b000);
      default: legal = 1'b0;
    endcase
  end

  assign tmo = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));

  // Extension by shifting the field to the top, then back down
  // logically (zero) or arithmetically (sign).
  always_comb begin
    sh = 7'd0;
    unique case (width_q)
      2'b00: sh = 7'(XLEN - 8);
      2'b01: sh = 7'(XLEN - 16);
      2'b10: sh = 7'(XLEN - 32);
      default: sh = 7'd0;
    endcase
  end

  assign lsh  = dmem_load << sh;
  assign slsh = lsh;
  assign zx   = lsh >> sh;
  assign sx   = slsh >>> sh;
  assign ext  = uns_q ? zx : sx;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      width_q <= 2'b00;
      wen_q   <= 1'b0;
      uns_q   <= 1'b0;
      cnt     <= '0;
      rdata   <= '0;
      err     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            if (legal) begin
              addr_q  <= req_addr;
              wdata_q <= req_wdata;
              width_q <= req_width;
              wen_q   <= req_wen;
              uns_q   <= req_unsigned;
              cnt     <= '0;
              state   <= ACCESS;
            end else begin
              err   <= 1'b1;
              rdata <= '0;
              state <= DONE;
            end
          end
        end
        ACCESS: begin
          // dhit takes priority over an expiring timeout
          if (dhit) begin
            err   <= 1'b0;
            rdata <= wen_q ? '0 : ext;
            state <= DONE;
          end else if (tmo) begin
            err   <= 1'b1;
            rdata <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign done       = (state == DONE);
  assign dmem_ren   = (state == ACCESS) & ~wen_q;
  assign dmem_wen   = (state == ACCESS) & wen_q;
  assign dmem_addr  = addr_q;
  assign dmem_store = wdata_q;
  assign dmem_width = width_q;
  assign stall      = nrst & (((state == IDLE) & req_valid) | (state == ACCESS));

endmodule

// File: tb/tb_ls_unit.sv
// tb_ls_unit: scoreboard bench for ls_unit, XLEN=32 and XLEN=64 instances, TIMEOUT=4.
// Stimulus pushes expected responses; monitors pop and compare on done.
module tb_ls_unit;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  logic        v32, v64, req_wen, req_unsigned, dhit;
  logic [1:0]  req_width;
  logic [63:0] req_addr, req_wdata, dmem_load;

  logic        s32, d32, e32, ren32, wen32;
  logic [31:0] rd32, a32, st32;
  logic [1:0]  dw32;
  logic        s64, d64, e64, ren64, wen64;
  logic [63:0] rd64, a64, st64;
  logic [1:0]  dw64;

  ls_unit #(.XLEN(32), .TIMEOUT(4)) u32 (
    .clk(clk), .nrst(nrst), .req_valid(v32), .req_wen(req_wen),
    .req_width(req_width), .req_unsigned(req_unsigned),
    .req_addr(req_addr[31:0]), .req_wdata(req_wdata[31:0]),
    .stall(s32), .done(d32), .rdata(rd32), .err(e32),
    .dmem_ren(ren32), .dmem_wen(wen32), .dmem_addr(a32),
    .dmem_store(st32), .dmem_width(dw32),
    .dmem_load(dmem_load[31:0]), .dhit(dhit)
  );

  ls_unit #(.XLEN(64), .TIMEOUT(4)) u64 (
    .clk(clk), .nrst(nrst), .req_valid(v64), .req_wen(req_wen),
    .req_width(req_width), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(s64), .done(d64), .rdata(rd64), .err(e64),
    .dmem_ren(ren64), .dmem_wen(wen64), .dmem_addr(a64),
    .dmem_store(st64), .dmem_width(dw64),
    .dmem_load(dmem_load), .dhit(dhit)
  );

  typedef struct {
    logic [63:0] rdata;
    logic        chk_rd;
    logic        err;
    int          ren;
    int          wen;
    int          stall;
    logic [63:0] addr;
    logic [63:0] store;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];
  exp_t x32, x64;
  int nchk = 0;
  int nerr = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(logic [63:0] rd, logic crd, logic er,
                              int rn, int wn, int st,
                              logic [63:0] ad, logic [63:0] sd);
    exp_t e;
    e.rdata = rd; e.chk_rd = crd; e.err = er;
    e.ren = rn; e.wen = wn; e.stall = st;
    e.addr = ad; e.store = sd;
    return e;
  endfunction

  int c_rn32, c_wn32, c_st32;
  logic [63:0] la32, ls32;
  always @(negedge clk) begin
    if (!nrst) begin
      c_rn32 = 0; c_wn32 = 0; c_st32 = 0;
    end else begin
      if (ren32 | wen32) la32 = {32'b0, a32};
      if (wen32) ls32 = {32'b0, st32};
      c_rn32 += int'(ren32);
      c_wn32 += int'(wen32);
      c_st32 += int'(s32);
      if (d32) begin
        if (q32.size() == 0) begin
          nchk++; nerr++;
          $display("FAIL u32 spurious done: got done=1 expected no response");
        end else begin
          x32 = q32.pop_front();
          if (x32.chk_rd) chk("u32 rdata", {32'b0, rd32}, x32.rdata);
          chk("u32 err", 64'(e32), 64'(x32.err));
          chk("u32 ren cycles", 64'(c_rn32), 64'(x32.ren));
          chk("u32 wen cycles", 64'(c_wn32), 64'(x32.wen));
          chk("u32 stall cycles", 64'(c_st32), 64'(x32.stall));
          if (x32.ren + x32.wen > 0) chk("u32 dmem_addr", la32, x32.addr);
          if (x32.wen > 0) chk("u32 dmem_store", ls32, x32.store);
        end
        c_rn32 = 0; c_wn32 = 0; c_st32 = 0;
      end
    end
  end

  int c_rn64, c_wn64, c_st64;
  logic [63:0] la64, ls64;
  always @(negedge clk) begin
    if (!nrst) begin
      c_rn64 = 0; c_wn64 = 0; c_st64 = 0;
    end else begin
      if (ren64 | wen64) la64 = a64;
      if (wen64) ls64 = st64;
      c_rn64 += int'(ren64);
      c_wn64 += int'(wen64);
      c_st64 += int'(s64);
      if (d64) begin
        if (q64.size() == 0) begin
          nchk++; nerr++;
          $display("FAIL u64 spurious done: got done=1 expected no response");
        end else begin
          x64 = q64.pop_front();
          if (x64.chk_rd) chk("u64 rdata", rd64, x64.rdata);
          chk("u64 err", 64'(e64), 64'(x64.err));
          chk("u64 ren cycles", 64'(c_rn64), 64'(x64.ren));
          chk("u64 wen cycles", 64'(c_wn64), 64'(x64.wen));
          chk("u64 stall cycles", 64'(c_st64), 64'(x64.stall));
          if (x64.ren + x64.wen > 0) chk("u64 dmem_addr", la64, x64.addr);
          if (x64.wen > 0) chk("u64 dmem_store", ls64, x64.store);
        end
        c_rn64 = 0; c_wn64 = 0; c_st64 = 0;
      end
    end
  end

  // ncyc: ACCESS cycles to drive; hit: index of the dhit cycle, -1 none
  task automatic req(bit is64, bit w, bit [1:0] wd, bit u,
                     logic [63:0] a, logic [63:0] wdat, logic [63:0] ld,
                     int hit, int ncyc, exp_t e);
    if (is64) q64.push_back(e);
    else q32.push_back(e);
    @(posedge clk) #1;
    v32 = !is64; v64 = is64;
    req_wen = w; req_width = wd; req_unsigned = u;
    req_addr = a; req_wdata = wdat; dmem_load = ld;
    @(posedge clk) #1;
    v32 = 1'b0; v64 = 1'b0;
    for (int k = 0; k < ncyc; k++) begin
      dhit = (k == hit);
      @(posedge clk) #1;
    end
    dhit = 1'b0;
    @(posedge clk) #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    nrst = 1'b0;
    v32 = 0; v64 = 0; req_wen = 0; req_unsigned = 0; dhit = 0;
    req_width = 2'b00; req_addr = '0; req_wdata = '0; dmem_load = '0;
    #1;
    chk("reset stall", 64'(s32), 64'd0);
    chk("reset done", 64'(d32), 64'd0);
    chk("reset ren/wen", 64'({ren32, wen32, ren64, wen64}), 64'd0);
    chk("reset rdata", rd64, 64'd0);
    @(negedge clk);
    nrst = 1'b1;

    // signed byte load, dhit first ACCESS cycle
    req(0, 0, 2'b00, 0, 64'h103, 0, 64'hF0, 0, 1,
        mk(64'hFFFF_FFF0, 1, 0, 1, 0, 2, 64'h103, 0));
    // store word, 3 wait cycles
    req(0, 1, 2'b10, 0, 64'h200, 64'hDEAD_BEEF, 0, 3, 4,
        mk(0, 0, 0, 0, 4, 5, 64'h200, 64'hDEAD_BEEF));
    // misaligned half
    req(0, 0, 2'b01, 0, 64'h101, 0, 0, -1, 0,
        mk(0, 0, 1, 0, 0, 1, 0, 0));
    // timeout
    req(0, 0, 2'b10, 0, 64'h300, 0, 64'h1234_5678, -1, 4,
        mk(0, 1, 1, 4, 0, 5, 64'h300, 0));
    // dhit on the timeout cycle wins
    req(0, 0, 2'b10, 0, 64'h300, 0, 64'h1234_5678, 3, 4,
        mk(64'h1234_5678, 1, 0, 4, 0, 5, 64'h300, 0));
    // double illegal on XLEN=32
    req(0, 0, 2'b11, 0, 64'h0, 0, 0, -1, 0,
        mk(0, 0, 1, 0, 0, 1, 0, 0));
    // unsigned byte
    req(0, 0, 2'b00, 1, 64'h103, 0, 64'hF0, 0, 1,
        mk(64'hF0, 1, 0, 1, 0, 2, 64'h103, 0));
    // signed half
    req(0, 0, 2'b01, 0, 64'h102, 0, 64'h8001, 1, 2,
        mk(64'hFFFF_8001, 1, 0, 2, 0, 3, 64'h102, 0));

    repeat (3) @(posedge clk);
    #1;
    chk("u32 rdata hold", {32'b0, rd32}, 64'hFFFF_8001);
    chk("u32 err hold", 64'(e32), 64'd0);

    // store byte
    req(0, 1, 2'b00, 0, 64'h5, 64'hAB, 0, 0, 1,
        mk(0, 0, 0, 0, 1, 2, 64'h5, 64'hAB));
    // load leaves nonzero rdata before the reset test
    req(0, 0, 2'b10, 0, 64'h44, 0, 64'hCAFE_F00D, 0, 1,
        mk(64'hCAFE_F00D, 1, 0, 1, 0, 2, 64'h44, 0));

    // XLEN=64 vectors
    req(1, 0, 2'b01, 1, 64'h10, 0, 64'hFFFF_FFFF_FFFF_8001, 0, 1,
        mk(64'h8001, 1, 0, 1, 0, 2, 64'h10, 0));
    req(1, 0, 2'b10, 0, 64'h8, 0, 64'h8000_0000, 1, 2,
        mk(64'hFFFF_FFFF_8000_0000, 1, 0, 2, 0, 3, 64'h8, 0));
    req(1, 0, 2'b11, 0, 64'h18, 0, 64'h0123_4567_89AB_CDEF, 0, 1,
        mk(64'h0123_4567_89AB_CDEF, 1, 0, 1, 0, 2, 64'h18, 0));
    req(1, 0, 2'b11, 0, 64'h1C, 0, 0, -1, 0,
        mk(0, 0, 1, 0, 0, 1, 0, 0));
    req(1, 0, 2'b00, 0, 64'h7, 0, 64'h7F, 0, 1,
        mk(64'h7F, 1, 0, 1, 0, 2, 64'h7, 0));
    req(1, 1, 2'b11, 0, 64'h20, 64'h1122_3344_5566_7788, 0, 2, 3,
        mk(0, 0, 0, 0, 3, 4, 64'h20, 64'h1122_3344_5566_7788));

    // reset in the 2nd ACCESS cycle of a load
    @(posedge clk) #1;
    v32 = 1'b1; req_wen = 0; req_width = 2'b10; req_unsigned = 0;
    req_addr = 64'h80; dmem_load = 64'h55;
    @(posedge clk) #1;
    v32 = 1'b0;
    @(posedge clk) #1;
    nrst = 1'b0;
    #1;
    chk("async rst stall", 64'(s32), 64'd0);
    chk("async rst done", 64'(d32), 64'd0);
    chk("async rst err", 64'(e32), 64'd0);
    chk("async rst enables", 64'({ren32, wen32}), 64'd0);
    chk("async rst rdata", {32'b0, rd32}, 64'd0);
    chk("async rst addr", {32'b0, a32}, 64'd0);
    chk("async rst store", {32'b0, st32}, 64'd0);
    @(negedge clk);
    @(posedge clk) #1;
    nrst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post rst idle", 64'({ren32, wen32, s32, d32}), 64'd0);
    end

    // recovery after reset
    req(0, 0, 2'b00, 0, 64'h103, 0, 64'hF0, 0, 1,
        mk(64'hFFFF_FFF0, 1, 0, 1, 0, 2, 64'h103, 0));

    repeat (3) @(posedge clk);
    #1;
    chk("u32 queue drained", 64'(q32.size()), 64'd0);
    chk("u64 queue drained", 64'(q64.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/ls_unit.md
LS_UNIT -- requirements
Module: ls_unit

Interface
REQ-001 Parameters SHALL be:
  - XLEN, default 32, data/address width; legal values 32 and 64.
  - TIMEOUT, default 16, maximum cycles spent in ACCESS before the request is aborted; 0 disables the timeout.
REQ-002 Ports SHALL be (name  direction  width  meaning):
  - clk  in  1  clock
  - nrst  in  1  reset
  - req_valid  in  1  decoded load/store present
  - req_wen  in  1  1=store, 0=load
  - req_width  in  2  00 byte, 01 half, 10 word, 11 double
  - req_unsigned  in  1  zero-extend load
  - req_addr  in  XLEN  effective address
  - req_wdata  in  XLEN  store data
  - stall  out  1  hold PC/instruction
  - done  out  1  access complete this cycle
  - rdata  out  XLEN  extended load value
  - err  out  1  misaligned/illegal/timeout, valid with done
  - dmem_ren  out  1  memory read enable
  - dmem_wen  out  1  memory write enable
  - dmem_addr  out  XLEN  memory address
  - dmem_store  out  XLEN  memory write data
  - dmem_width  out  2  memory access width
  - dmem_load  in  XLEN  memory read data
  - dhit  in  1  memory completion
REQ-003 The block SHALL use one clock, clk; reset nrst SHALL be asynchronous and active-low.

Function
REQ-004 The FSM SHALL have states IDLE, ACCESS and DONE, and SHALL reset to IDLE.
REQ-005 IDLE with req_valid=1 and a legal, aligned request SHALL latch addr, wdata, width, wen and unsigned, clear the cycle counter, and go to ACCESS.
REQ-006 Alignment rules: half needs addr[0]=0; word needs addr[1:0]=0; double needs addr[2:0]=0. width=11 SHALL be illegal when XLEN=32.
REQ-007 IDLE with req_valid=1 and a misaligned or illegal request SHALL go to DONE with err latched to 1, and SHALL issue no memory enable.
REQ-008 In ACCESS, dmem_ren/dmem_wen SHALL equal the latched ~wen/wen. dmem_addr, dmem_store and dmem_width SHALL come from the latched registers only.
REQ-009 Outside ACCESS, dmem_ren=dmem_wen=0. No enable SHALL depend combinationally on dhit.
REQ-010 ACCESS with dhit=1 SHALL go to DONE; for loads, rdata SHALL be captured the same edge, with err=0.
REQ-011 ACCESS without dhit SHALL increment the counter (width clog2(TIMEOUT+1)).
REQ-012 When TIMEOUT≠0 and the counter equals TIMEOUT-1 with dhit=0, the FSM SHALL go to DONE with err=1 and rdata=0.
REQ-013 dhit arriving on the same cycle as the timeout SHALL win: the access succeeds with err=0.
REQ-014 DONE SHALL last exactly one cycle with done=1, then return to IDLE. req_valid SHALL be ignored in DONE.
REQ-015 stall SHALL equal (IDLE & req_valid) | ACCESS; stall SHALL be 0 in DONE.
REQ-016 Load extension from dmem_load SHALL be:
  - byte: bits [7:0]
  - half: bits [15:0]
  - word: bits [31:0]
  - double: all XLEN bits
  - Sign-extended unless req_unsigned=1, then zero-extended.
  - Word with XLEN=32 SHALL pass through unchanged.
REQ-017 rdata and err SHALL hold their values until the next DONE.
REQ-018 Minimum latency SHALL be 3 cycles: IDLE, ACCESS with dhit, DONE. Back-to-back requests SHALL incur one IDLE cycle between them.
REQ-019 dhit in IDLE or DONE SHALL be ignored.

Reset
REQ-020 nrst=0 SHALL immediately force:
  - state to IDLE
  - stall, done, err, dmem_ren, dmem_wen to 0
  - rdata, dmem_addr, dmem_store, latched registers and counter to 0
REQ-021 Reset asserted mid-ACCESS SHALL abandon the request. No enable SHALL be asserted on the first cycle after release unless req_valid is sampled in IDLE.

Verification
REQ-022 Signed byte load: addr=0x103, width=00, unsigned=0, dmem_load=0x000000F0, dhit on the 1st ACCESS cycle -> dmem_ren=1 for 1 cycle, then done=1, rdata=0xFFFFFFF0, err=0.
REQ-023 Store word: addr=0x200, wdata=0xDEADBEEF, dhit after 3 wait cycles -> dmem_wen=1 for 4 cycles, dmem_store=0xDEADBEEF, stall=1 for 5 cycles, then done=1.
REQ-024 Misaligned half: addr=0x101 -> no dmem_ren/wen ever; next cycle done=1, err=1.
REQ-025 Timeout: TIMEOUT=4, dhit never asserted -> dmem_ren=1 for exactly 4 cycles, then done=1, err=1, rdata=0. Variant with dhit on the 4th cycle -> err=0.
REQ-026 XLEN=64 unsigned half load: dmem_load=0x...8001 -> rdata=0x0000000000008001. Also, width=11 with XLEN=32 -> err=1.
REQ-027 nrst pulsed low in the 2nd ACCESS cycle -> all outputs 0 asynchronously; after release with req_valid=0 -> block stays IDLE, no enables asserted.
